// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the two-read/one-write register file.
package regfile_pkg;

    localparam int unsigned RF_WIDTH = 16;
    localparam int unsigned RF_DEPTH = 8;

    typedef logic [RF_WIDTH-1:0] reg_word_t;

    // True when idx names a writable register: in range and not a hardwired zero.
    function automatic logic idx_legal(input int unsigned idx, input int unsigned depth,
                                       input logic zero_reg);
        return (idx < depth) && !(zero_reg && (idx == 0));
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, array mux, write-through bypass, zero override.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = RF_WIDTH,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
    input  logic [DEPTH-1:0]            valid_i,
    input  logic [AW-1:0]               readnum_i,
    input  logic                        wr_fire_i,
    input  logic [AW-1:0]               writenum_i,
    input  logic [WIDTH-1:0]            data_in_i,
    output logic [WIDTH-1:0]            data_o,
    output logic                        valid_o
);

    always_comb begin
        data_o  = '0;
        valid_o = 1'b0;
        if (32'(readnum_i) < DEPTH) begin
            data_o  = regs_i[readnum_i];
            valid_o = valid_i[readnum_i];
        end
        // wr_fire_i already excludes reset and illegal indices.
        if ((BYPASS != 0) && wr_fire_i && (writenum_i == readnum_i)) begin
            data_o  = data_in_i;
            valid_o = 1'b1;
        end
        if ((ZERO_REG != 0) && (readnum_i == '0)) begin
            data_o  = '0;
            valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file with two combinational read ports, one write port,
// optional write-through bypass, optional hardwired-zero R0 and per-register valid flags.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = RF_WIDTH,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [$clog2(DEPTH)-1:0] writenum,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(DEPTH)-1:0] readnum_a,
    output logic [WIDTH-1:0]         data_out_a,
    output logic                     valid_a,
    input  logic [$clog2(DEPTH)-1:0] readnum_b,
    output logic [WIDTH-1:0]         data_out_b,
    output logic                     valid_b
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic                        wr_fire;

    assign wr_fire = write && !reset && idx_legal(32'(writenum), DEPTH, ZERO_REG != 0);

    always_comb begin
        regs_d  = regs_q;
        valid_d = valid_q;
        if (wr_fire) begin
            regs_d[writenum]  = data_in;
            valid_d[writenum] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q  <= '0;
            valid_q <= '0;
        end else begin
            regs_q  <= regs_d;
            valid_q <= valid_d;
        end
    end

    regfile_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS),
        .AW      (AW)
    ) u_port_a (
        .regs_i    (regs_q),
        .valid_i   (valid_q),
        .readnum_i (readnum_a),
        .wr_fire_i (wr_fire),
        .writenum_i(writenum),
        .data_in_i (data_in),
        .data_o    (data_out_a),
        .valid_o   (valid_a)
    );

    regfile_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS),
        .AW      (AW)
    ) u_port_b (
        .regs_i    (regs_q),
        .valid_i   (valid_q),
        .readnum_i (readnum_b),
        .wr_fire_i (wr_fire),
        .writenum_i(writenum),
        .data_in_i (data_in),
        .data_o    (data_out_b),
        .valid_o   (valid_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: four configurations share one stimulus; a scoreboard checks outputs.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset, write;
    logic [2:0]  writenum, readnum_a, readnum_b;
    logic [15:0] data_in;

    // 0: D8 Z0 B1, 1: D8 Z0 B0, 2: D8 Z1 B1, 3: D6 Z0 B1
    logic [3:0][15:0] dout_a, dout_b;
    logic [3:0]       va, vb;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
        .readnum_a(readnum_a), .data_out_a(dout_a[0]), .valid_a(va[0]),
        .readnum_b(readnum_b), .data_out_b(dout_b[0]), .valid_b(vb[0])
    );
    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
        .readnum_a(readnum_a), .data_out_a(dout_a[1]), .valid_a(va[1]),
        .readnum_b(readnum_b), .data_out_b(dout_b[1]), .valid_b(vb[1])
    );
    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) u_dut2 (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
        .readnum_a(readnum_a), .data_out_a(dout_a[2]), .valid_a(va[2]),
        .readnum_b(readnum_b), .data_out_b(dout_b[2]), .valid_b(vb[2])
    );
    regfile_2r1w #(.WIDTH(16), .DEPTH(6), .ZERO_REG(0), .BYPASS(1)) u_dut3 (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
        .readnum_a(readnum_a), .data_out_a(dout_a[3]), .valid_a(va[3]),
        .readnum_b(readnum_b), .data_out_b(dout_b[3]), .valid_b(vb[3])
    );

    typedef struct {
        bit          rst;
        bit          wr;
        logic [2:0]  wn;
        logic [15:0] din;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] ea;
        bit          eva;
        logic [15:0] eb;
        bit          evb;
    } vec_t;

    typedef struct {
        string       name;
        int          dut;
        bit          port_b;
        logic [15:0] d;
        bit          v;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Inputs change 1 time unit after the rising edge.
    task automatic step(input bit r, input bit w, input logic [2:0] wn, input logic [15:0] din,
                        input logic [2:0] ra, input logic [2:0] rb);
        @(posedge clk);
        #1;
        reset     = r;
        write     = w;
        writenum  = wn;
        data_in   = din;
        readnum_a = ra;
        readnum_b = rb;
    endtask

    task automatic expect_out(input string name, input int dut, input bit port_b,
                              input logic [15:0] d, input bit v);
        exp_t e;
        e.name = name; e.dut = dut; e.port_b = port_b; e.d = d; e.v = v;
        sb.push_back(e);
    endtask

    // Combinational outputs are sampled on the falling edge, before the next commit.
    task automatic check();
        exp_t        e;
        logic [15:0] ad;
        logic        av;
        @(negedge clk);
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            ad = e.port_b ? dout_b[e.dut] : dout_a[e.dut];
            av = e.port_b ? vb[e.dut] : va[e.dut];
            n_checks++;
            if (ad !== e.d || av !== e.v) begin
                n_fail++;
                $display("FAIL %s: got data=%h valid=%b, want data=%h valid=%b",
                         e.name, ad, av, e.d, e.v);
            end
        end
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; writenum = '0; data_in = '0;
        readnum_a = '0; readnum_b = '0;

        // Test 1: after reset every index reads zero and invalid.
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 16'h0, 1'b0, 16'h0, 1'b0});
        // Test 2: r0 then r1, each visible via bypass in its write cycle.
        vecs.push_back('{1'b0, 1'b1, 3'd0, 16'h0042, 3'd0, 3'd1, 16'h0042, 1'b1, 16'h0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd1, 16'h0023, 3'd0, 3'd1, 16'h0042, 1'b1, 16'h0023, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 16'h0042, 1'b1, 16'h0023, 1'b1});
        // Test 3: bypass on both ports sharing one index.
        vecs.push_back('{1'b0, 1'b1, 3'd5, 16'hFFFF, 3'd5, 3'd5, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd4, 16'hFFFF, 1'b1, 16'h0, 1'b0});
        // Test 4: write disabled leaves r1 untouched.
        vecs.push_back('{1'b0, 1'b0, 3'd1, 16'hEEEE, 3'd1, 3'd1, 16'h0023, 1'b1, 16'h0023, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 3'd1, 16'hEEEE, 3'd1, 3'd0, 16'h0023, 1'b1, 16'h0042, 1'b1});
        // Reset together with a write: no bypass, then everything cleared.
        vecs.push_back('{1'b1, 1'b1, 3'd3, 16'h003A, 3'd3, 3'd0, 16'h0, 1'b0, 16'h0042, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0});

        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].wn, vecs[i].din, vecs[i].ra, vecs[i].rb);
            expect_out($sformatf("vec%0d_a", i), 0, 1'b0, vecs[i].ea, vecs[i].eva);
            expect_out($sformatf("vec%0d_b", i), 0, 1'b1, vecs[i].eb, vecs[i].evb);
            check();
        end

        // BYPASS=0 holds the old value until the edge; BYPASS=1 forwards.
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        step(1'b0, 1'b1, 3'd5, 16'hFFFF, 3'd5, 3'd5);
        expect_out("nobyp_pre", 1, 1'b0, 16'h0, 1'b0);
        expect_out("byp_pre", 0, 1'b0, 16'hFFFF, 1'b1);
        check();
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd5);
        expect_out("nobyp_post", 1, 1'b0, 16'hFFFF, 1'b1);
        check();

        // ZERO_REG=1: R0 reads 0/valid even while written and after the edge.
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        expect_out("zero_in_reset", 2, 1'b0, 16'h0, 1'b1);
        check();
        step(1'b0, 1'b1, 3'd0, 16'h1234, 3'd0, 3'd0);
        expect_out("zero_pre_a", 2, 1'b0, 16'h0, 1'b1);
        expect_out("zero_pre_b", 2, 1'b1, 16'h0, 1'b1);
        expect_out("r0_normal_pre", 0, 1'b0, 16'h1234, 1'b1);
        check();
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        expect_out("zero_post", 2, 1'b0, 16'h0, 1'b1);
        expect_out("r0_normal_post", 0, 1'b0, 16'h1234, 1'b1);
        check();

        // DEPTH=6: out-of-range write dropped and not bypassed; out-of-range read is zero.
        step(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        step(1'b0, 1'b1, 3'd7, 16'hBEEF, 3'd7, 3'd7);
        expect_out("d6_oor_byp_a", 3, 1'b0, 16'h0, 1'b0);
        expect_out("d6_oor_byp_b", 3, 1'b1, 16'h0, 1'b0);
        expect_out("d8_r7_byp", 0, 1'b0, 16'hBEEF, 1'b1);
        check();
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd7);
        expect_out("d6_r5_unchanged", 3, 1'b0, 16'h0, 1'b0);
        expect_out("d6_oor_read", 3, 1'b1, 16'h0, 1'b0);
        expect_out("d8_r7_stored", 0, 1'b1, 16'hBEEF, 1'b1);
        check();
        step(1'b0, 1'b1, 3'd3, 16'h1111, 3'd3, 3'd0);
        expect_out("d6_r3_byp", 3, 1'b0, 16'h1111, 1'b1);
        check();
        step(1'b1, 1'b1, 3'd3, 16'h003A, 3'd3, 3'd0);
        expect_out("d6_reset_no_byp", 3, 1'b0, 16'h1111, 1'b1);
        check();
        step(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
        expect_out("d6_r3_cleared", 3, 1'b0, 16'h0, 1'b0);
        expect_out("d8_r3_cleared", 0, 1'b1, 16'h0, 1'b0);
        check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
